// File: rtl/sync_frame_capture.sv
// sync_frame_capture: after each sync strobe from the 1101 detector, shifts
// the next WIDTH serial bits into a payload word and offers it downstream.
//
// Handshake: frame_data is meaningful while frame_valid=1; a transfer happens
// on any rising edge where frame_valid & frame_ready are both 1. frame_valid
// never drops without a transfer, and frame_data holds steady while valid.
module sync_frame_capture #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             data_in,
    input  logic             detected,
    input  logic             frame_ready,
    output logic [WIDTH-1:0] frame_data,
    output logic             frame_valid,
    output logic             busy,
    output logic [15:0]      frame_count,
    output logic [7:0]       drop_count
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    // Count value seen on the edge that samples the final payload bit.
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [15:0]      fcnt_q, fcnt_d;
    logic [7:0]       dcnt_q, dcnt_d;

    // Next-state logic: sync detection, bit shifting, handshake and counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        fcnt_d  = fcnt_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            IDLE: begin
                if (detected) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            CAPTURE: begin
                // detected is deliberately ignored here: a 1101 inside the
                // payload is data, not a new sync.
                shift_d = {shift_q[WIDTH-2:0], data_in};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = HOLD;
                    data_d  = {shift_q[WIDTH-2:0], data_in};
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    fcnt_d = fcnt_q + 16'd1;
                    if (detected) begin
                        // Sync on the handshake edge chains straight into
                        // the next capture, so it is not a drop.
                        state_d = CAPTURE;
                        cnt_d   = '0;
                        shift_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (detected && (dcnt_q != 8'hFF)) begin
                    dcnt_d = dcnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            fcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            fcnt_q  <= fcnt_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign frame_data  = data_q;
    assign frame_valid = (state_q == HOLD);
    assign busy        = (state_q == CAPTURE);
    assign frame_count = fcnt_q;
    assign drop_count  = dcnt_q;

endmodule

// File: tb/tb_sync_frame_capture.sv
// Bench for sync_frame_capture (WIDTH=8): directed scenarios followed by a
// random phase, all compared against a frame-level reference model.
module tb_sync_frame_capture;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         data_in = 1'b0;
    logic         detected = 1'b0;
    logic         frame_ready = 1'b0;
    logic [W-1:0] frame_data;
    logic         frame_valid;
    logic         busy;
    logic [15:0]  frame_count;
    logic [7:0]   drop_count;

    int checks = 0;
    int failures = 0;

    // Reference model: bits still owed to the current payload, the payload
    // value accumulated arithmetically, and a held frame awaiting transfer.
    int           m_left = 0;
    int           m_acc = 0;
    bit           m_hold = 0;
    int           m_data = 0;
    int           m_fc = 0;
    int           m_dc = 0;
    logic [W-1:0] exp_q[$];

    sync_frame_capture #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .detected    (detected),
        .frame_ready (frame_ready),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .busy        (busy),
        .frame_count (frame_count),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_acc  = 0;
        m_hold = 0;
        m_data = 0;
        m_fc   = 0;
        m_dc   = 0;
        exp_q.delete();
    endtask

    task automatic model_edge(input bit det, input bit din, input bit rdy);
        if (m_left > 0) begin
            m_acc  = (m_acc * 2 + int'(din)) % (1 << W);
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_hold = 1;
                m_data = m_acc;
                exp_q.push_back(W'(m_acc));
            end
        end else if (m_hold) begin
            if (rdy) begin
                m_fc   = (m_fc + 1) % 65536;
                m_hold = 0;
                if (det) begin
                    m_left = W;
                    m_acc  = 0;
                end
            end else if (det && m_dc < 255) begin
                m_dc = m_dc + 1;
            end
        end else if (det) begin
            m_left = W;
            m_acc  = 0;
        end
    endtask

    task automatic compare_model();
        check_val("busy", 32'(busy), 32'(m_left > 0));
        check_val("frame_valid", 32'(frame_valid), 32'(m_hold));
        check_val("frame_data", 32'(frame_data), 32'(m_data));
        check_val("frame_count", 32'(frame_count), 32'(m_fc));
        check_val("drop_count", 32'(drop_count), 32'(m_dc));
    endtask

    // One clock: drive at the falling edge, model the rising edge, compare 1ns later.
    task automatic step(input bit det, input bit din, input bit rdy);
        logic [W-1:0] e;
        @(negedge clk);
        detected    = det;
        data_in     = din;
        frame_ready = rdy;
        #1;
        if (frame_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check_val("handshake_unexpected", 32'(frame_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("handshake_data", 32'(frame_data), 32'(e));
            end
        end
        @(posedge clk);
        model_edge(det, din, rdy);
        #1;
        compare_model();
    endtask

    task automatic send_payload(input logic [W-1:0] p, input bit rdy);
        for (int i = W - 1; i >= 0; i--) step(1'b0, p[i], rdy);
    endtask

    // Reset asserted between edges; outputs must clear without a clock.
    task automatic apply_reset();
        @(negedge clk);
        detected    = 1'b0;
        frame_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_val("rst_frame_data", 32'(frame_data), 32'd0);
        check_val("rst_frame_valid", 32'(frame_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_frame_count", 32'(frame_count), 32'd0);
        check_val("rst_drop_count", 32'(drop_count), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] p;
        bit det_r, rdy_r;

        apply_reset();

        // Basic capture of 0xA3 with the consumer ready throughout.
        step(1'b1, 1'b0, 1'b1);
        send_payload(8'hA3, 1'b1);
        check_val("basic_valid", 32'(frame_valid), 32'd1);
        check_val("basic_data", 32'(frame_data), 32'hA3);
        step(1'b0, 1'b0, 1'b1);
        check_val("basic_count", 32'(frame_count), 32'd1);
        check_val("basic_valid_fall", 32'(frame_valid), 32'd0);

        // Backpressure: two syncs while 0x5C waits are dropped.
        apply_reset();
        step(1'b1, 1'b0, 1'b0);
        send_payload(8'h5C, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        check_val("bp_data", 32'(frame_data), 32'h5C);
        check_val("bp_drops", 32'(drop_count), 32'd2);
        step(1'b0, 1'b0, 1'b1);
        check_val("bp_count", 32'(frame_count), 32'd1);
        check_val("bp_idle_valid", 32'(frame_valid), 32'd0);
        check_val("bp_idle_busy", 32'(busy), 32'd0);

        // Sync inside payload 0xD0 is ignored.
        apply_reset();
        step(1'b1, 1'b0, 1'b0);
        p = 8'hD0;
        for (int i = W - 1; i >= 0; i--) step(i == 4 || i == 2, p[i], 1'b0);
        check_val("inpay_valid", 32'(frame_valid), 32'd1);
        check_val("inpay_data", 32'(frame_data), 32'hD0);
        check_val("inpay_drops", 32'(drop_count), 32'd0);

        // Handshake and sync on the same edge chain into 0xFF.
        apply_reset();
        step(1'b1, 1'b0, 1'b0);
        send_payload(8'h21, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check_val("chain_busy", 32'(busy), 32'd1);
        send_payload(8'hFF, 1'b0);
        check_val("chain_valid", 32'(frame_valid), 32'd1);
        check_val("chain_data", 32'(frame_data), 32'hFF);
        step(1'b0, 1'b0, 1'b1);
        check_val("chain_count", 32'(frame_count), 32'd2);
        check_val("chain_drops", 32'(drop_count), 32'd0);

        // Reset after 4 payload bits, then a fresh 0x3C frame.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0);
        apply_reset();
        step(1'b1, 1'b0, 1'b0);
        send_payload(8'h3C, 1'b0);
        check_val("post_rst_data", 32'(frame_data), 32'h3C);

        // Drop counter saturation with 300 sync pulses held off.
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        check_val("sat_drops", 32'(drop_count), 32'd255);
        check_val("sat_data", 32'(frame_data), 32'h3C);
        step(1'b0, 1'b0, 1'b1);

        // Random traffic.
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            det_r = ($urandom_range(0, 3) == 0);
            rdy_r = ($urandom_range(0, 2) != 0);
            step(det_r, 1'($urandom_range(0, 1)), rdy_r);
        end
        check_val("rand_frames_seen", 32'(frame_count != 16'd0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sync_frame_capture.md
# sync_frame_capture

Downstream consumer of the 1101 sequence detector. Each `detected` pulse marks a sync word. The block then deserialises the next WIDTH bits of the same serial stream into a parallel payload word. It presents that word on a valid/ready handshake and keeps running frame and drop counters for status reporting.

## Interface
- `WIDTH`, 8, payload bits captured per sync; legal range 2..32.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `data_in`  in  1  serial stream, the same stream that feeds the detector, aligned so the first payload bit is present at the edge after the one that samples `detected`.
- `detected`  in  1  sync-found strobe from the detector, one cycle per detection.
- `frame_ready`  in  1  consumer can accept `frame_data`.
- `frame_data`  out  WIDTH  captured payload, first-received bit in MSB.
- `frame_valid`  out  1  `frame_data` holds a complete payload.
- `busy`  out  1  high while in CAPTURE.
- `frame_count`  out  16  frames handed off; wraps 0xFFFF to 0.
- `drop_count`  out  8  syncs discarded while a frame was waiting; saturates at 255.

## Operation
- FSM states: IDLE, CAPTURE, HOLD. The reset state is IDLE.
- IDLE: if `detected`=1 at an edge, go to CAPTURE. The bit counter clears to 0 and the shift register clears.
- CAPTURE: on each edge, `data_in` shifts into the shift register (shift left, new bit into the LSB) and the bit counter increments. On the edge that samples bit WIDTH, go to HOLD and load `frame_data`.
- CAPTURE ignores `detected`. A sync pattern inside the payload neither restarts capture nor counts as a drop.
- HOLD: `frame_valid`=1 and `frame_data` is stable.
  - An edge with `frame_valid`&`frame_ready` completes the handshake and increments `frame_count`.
  - After a handshake, go to IDLE. If `detected`=1 at that same edge, go directly to CAPTURE instead. No drop is counted in that case.
  - In HOLD without a handshake, `detected`=1 increments `drop_count`, saturating at 255. State is unchanged.
- `frame_ready` is ignored outside HOLD.
- Width rules:
  - The bit counter is $clog2(WIDTH+1) bits wide.
  - `frame_count` uses natural 16-bit wrap.
  - `drop_count` holds at 255 and never wraps.
- Reset mid-operation discards any partial or held payload. Both counters are cleared.

## Timing
- Reset values: `frame_data`=0, `frame_valid`=0, `busy`=0, `frame_count`=0, `drop_count`=0.
- `detected` sampled at edge k:
  - payload bits are sampled at edges k+1..k+WIDTH;
  - `busy` is high after edge k until after edge k+WIDTH;
  - `frame_valid` rises after edge k+WIDTH.
- Minimum sync-to-valid latency is WIDTH+1 edges, counting the sync edge.
- `frame_valid` falls after the handshake edge. It is never deasserted without a handshake.
- `frame_data` changes only when a new frame loads into HOLD.
- All outputs are registered. There is no combinational path from input to output.
- Back-to-back throughput: one frame per WIDTH+1 cycles when `frame_ready`=1 and syncs coincide with handshake edges.

## Test plan
All scenarios use WIDTH=8.
- **Basic capture:** pulse `detected`, then drive bits 1,0,1,0,0,0,1,1 with `frame_ready`=1.
  - `frame_valid` rises 8 edges after the sync edge with `frame_data`=0xA3.
  - One handshake occurs, `frame_count`=1, and `frame_valid` drops the next cycle.
- **Backpressure:** capture 0x5C with `frame_ready`=0, then pulse `detected` twice.
  - `frame_data` stays 0x5C and `drop_count`=2.
  - Raise `frame_ready`: one handshake, `frame_count`=1, FSM returns to IDLE.
- **Sync inside payload:** after a sync, drive payload 1,1,0,1,0,0,0,0 with `detected` pulsed during capture.
  - `frame_data`=0xD0, `drop_count`=0, and no restart occurs (`frame_valid` timing unchanged).
- **Simultaneous handshake and sync:** in HOLD, assert `frame_ready` and `detected` on the same edge, then drive payload 0xFF.
  - The first frame is accepted.
  - The second frame is valid 8 edges later with `frame_data`=0xFF, `frame_count`=2, `drop_count`=0.
- **Asynchronous reset mid-capture:** assert `reset` between edges after 4 payload bits.
  - All outputs read 0 immediately.
  - A fresh sync followed by payload 0x3C yields `frame_data`=0x3C.
- **Drop saturation:** hold `frame_ready`=0 in HOLD and pulse `detected` 300 times.
  - `drop_count`=255 and `frame_data` is unchanged.
